// File: rtl/parking_pkg.sv
// Shared types for the parking gate pipeline: beam FSM state encoding and the
// reduced timing constants used when simulating the gate detector.
package parking_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ENT_O,
    ENT_OI,
    ENT_I,
    EXT_I,
    EXT_IO,
    EXT_O,
    WAIT_CLR,
    FAULT
  } beam_state_t;

  localparam int unsigned BENCH_DEBOUNCE_CYCLES = 4;
  localparam int unsigned BENCH_TIMEOUT_CYCLES  = 64;

endpackage

// File: rtl/beam_filter.sv
// 2-FF synchronizer plus debounce for one IR beam; a stable raw level reaches
// filtered DEBOUNCE_CYCLES+2 edges after it is first sampled.
module beam_filter
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int unsigned       CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             meta;
  logic             synced;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 1'b0;
      synced   <= 1'b0;
      cnt      <= '0;
      filtered <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
      // Any return to the filtered level restarts the stability count.
      if (synced == filtered) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        filtered <= synced;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/beam_direction_detector.sv
// Two-beam lane gate: debounced beam sequence -> one entry/exit pulse per passage.
// Optional BEAM_DIR_COUNTERS_EN adds saturating entry/exit totals with clr_totals.
module beam_direction_detector
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000,
  parameter int unsigned TMO_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beam_outer_raw,
  input  logic       beam_inner_raw,
`ifdef BEAM_DIR_COUNTERS_EN
  input  logic       clr_totals,
  output logic [7:0] entry_total,
  output logic [7:0] exit_total,
`endif
  output logic       entry_pulse,
  output logic       exit_pulse,
  output logic       busy,
  output logic       fault
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  logic             outer_filt;
  logic             inner_filt;
  logic [1:0]       beams;
  beam_state_t      state;
  beam_state_t      state_nxt;
  logic             entry_nxt;
  logic             exit_nxt;
  logic [TMO_W-1:0] tmo_cnt;

  beam_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_outer_filter (
    .clk      (clk),
    .reset    (reset),
    .raw      (beam_outer_raw),
    .filtered (outer_filt)
  );

  beam_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inner_filter (
    .clk      (clk),
    .reset    (reset),
    .raw      (beam_inner_raw),
    .filtered (inner_filt)
  );

  assign beams = {outer_filt, inner_filt};

  always_comb begin
    state_nxt = state;
    entry_nxt = 1'b0;
    exit_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        case (beams)
          2'b10:   state_nxt = ENT_O;
          2'b01:   state_nxt = EXT_I;
          2'b11:   state_nxt = WAIT_CLR;
          default: state_nxt = IDLE;
        endcase
      end
      ENT_O: begin
        case (beams)
          2'b11:   state_nxt = ENT_OI;
          2'b00:   state_nxt = IDLE;
          2'b01:   state_nxt = WAIT_CLR;
          default: state_nxt = ENT_O;
        endcase
      end
      ENT_OI: begin
        case (beams)
          2'b01:   state_nxt = ENT_I;
          2'b10:   state_nxt = ENT_O;
          2'b00:   state_nxt = WAIT_CLR;
          default: state_nxt = ENT_OI;
        endcase
      end
      ENT_I: begin
        case (beams)
          2'b00: begin
            state_nxt = IDLE;
            entry_nxt = 1'b1;
          end
          2'b11:   state_nxt = ENT_OI;
          2'b10:   state_nxt = WAIT_CLR;
          default: state_nxt = ENT_I;
        endcase
      end
      EXT_I: begin
        case (beams)
          2'b11:   state_nxt = EXT_IO;
          2'b00:   state_nxt = IDLE;
          2'b10:   state_nxt = WAIT_CLR;
          default: state_nxt = EXT_I;
        endcase
      end
      EXT_IO: begin
        case (beams)
          2'b10:   state_nxt = EXT_O;
          2'b01:   state_nxt = EXT_I;
          2'b00:   state_nxt = WAIT_CLR;
          default: state_nxt = EXT_IO;
        endcase
      end
      EXT_O: begin
        case (beams)
          2'b00: begin
            state_nxt = IDLE;
            exit_nxt  = 1'b1;
          end
          2'b11:   state_nxt = EXT_IO;
          2'b01:   state_nxt = WAIT_CLR;
          default: state_nxt = EXT_O;
        endcase
      end
      WAIT_CLR, FAULT: begin
        if (beams == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A stuck passage is abandoned outright; the timeout wins over any move.
    if (state != IDLE && state != FAULT && tmo_cnt == TMO_MAX) begin
      state_nxt = FAULT;
      entry_nxt = 1'b0;
      exit_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      entry_pulse <= entry_nxt;
      exit_pulse  <= exit_nxt;
      busy        <= (state_nxt != IDLE);
      fault       <= (state_nxt == FAULT);
      if (state_nxt == IDLE || state_nxt != state) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

`ifdef BEAM_DIR_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset || clr_totals) begin
      entry_total <= '0;
      exit_total  <= '0;
    end else begin
      if (entry_pulse && entry_total != 8'hFF) entry_total <= entry_total + 1'b1;
      if (exit_pulse && exit_total != 8'hFF)   exit_total  <= exit_total + 1'b1;
    end
  end
`endif

endmodule
